// File: rtl/exp_range_reducer.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// exp_range_reducer
//
// Argument-reduction stage in front of the CORDIC exponential. It splits a
// signed fixed-point argument x into x = k*ln2 + r with |r| <= ln2/2.
//   - r goes to the CORDIC as its angle, inside the hyperbolic convergence range.
//   - k goes to the downstream 2^k shifter.
// Each cycle removes at most one ln2 step. If |k| reaches K_MAX while r is still
// out of range, the result saturates: r is clamped to +/-HALF and ovf or unf is
// raised.
//
// Ports
//   clk        in   rising-edge clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   argument valid
//   in_ready   out  block can accept an argument (IDLE only)
//   x_in       in   signed argument, Q(ANG_W-FRAC-1).FRAC
//   out_valid  out  result valid (DONE only)
//   out_ready  in   consumer accepts result
//   r_out      out  signed reduced argument (CORDIC angle), same format as x_in
//   k_out      out  signed power-of-two exponent
//   ovf        out  positive saturation: k hit K_MAX with r still above HALF
//   unf        out  negative saturation: k hit -K_MAX with r still below -HALF
// -----------------------------------------------------------------------------
module exp_range_reducer #(
  parameter int ANG_W = 32,
  parameter int FRAC  = 16,
  parameter int K_W   = 6,
  parameter int K_MAX = 24,
  parameter int LN2   = 45426,
  parameter int HALF  = 22713
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [ANG_W-1:0] x_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ANG_W-1:0] r_out,
  output logic signed [K_W-1:0]   k_out,
  output logic                    ovf,
  output logic                    unf
);

  // Elaboration-time consistency check. HALF must be LN2>>1, K_MAX must fit
  // in k, and the binary point must lie inside the word.
  if (HALF != (LN2 >> 1) || K_MAX >= (1 << (K_W - 1)) || FRAC >= ANG_W) begin : g_bad_params
    $error("exp_range_reducer: inconsistent parameters");
  end

  localparam logic signed [ANG_W-1:0] LN2_S      = ANG_W'(LN2);
  localparam logic signed [ANG_W-1:0] HALF_S     = ANG_W'(HALF);
  localparam logic signed [ANG_W-1:0] NEG_HALF_S = -ANG_W'(HALF);
  localparam logic signed [K_W-1:0]   K_MAX_S    = K_W'(K_MAX);
  localparam logic signed [K_W-1:0]   NEG_K_MAX_S = -K_W'(K_MAX);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_REDUCE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                  r_state;
  logic signed [ANG_W-1:0] r_angle;
  logic signed [K_W-1:0]   r_k;
  logic                    r_ovf;
  logic                    r_unf;
  logic                    r_out_valid;
  logic                    r_in_ready;

  // Range tests on the running remainder. Both bounds are inclusive.
  logic w_above;
  logic w_below;
  assign w_above = (r_angle > HALF_S);
  assign w_below = (r_angle < NEG_HALF_S);

  // NOTE: every state register is written with <= so all of them update
  // together from the values seen at the same edge. Blocking assignments here
  // would make later lines read values already updated in this same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_angle     <= '0;
      r_k         <= '0;
      r_ovf       <= 1'b0;
      r_unf       <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid && r_in_ready) begin
            r_angle    <= x_in;
            r_k        <= '0;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= S_REDUCE;
          end
        end

        S_REDUCE: begin
          if (!w_above && !w_below) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_above && r_k == K_MAX_S) begin
            // Out of shifter range: clamp r so the CORDIC still converges.
            r_ovf       <= 1'b1;
            r_angle     <= HALF_S;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_below && r_k == NEG_K_MAX_S) begin
            r_unf       <= 1'b1;
            r_angle     <= NEG_HALF_S;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_above) begin
            // The step always moves r toward zero, so it cannot wrap.
            r_angle <= r_angle - LN2_S;
            r_k     <= r_k + K_W'(1);
          end else begin
            r_angle <= r_angle + LN2_S;
            r_k     <= r_k - K_W'(1);
          end
        end

        S_DONE: begin
          // The outputs stay frozen until the consumer takes the result.
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign r_out     = r_angle;
  assign k_out     = r_k;
  assign ovf       = r_ovf;
  assign unf       = r_unf;

endmodule

// File: tb/tb_exp_range_reducer.sv
`timescale 1ns/1ps
module tb_exp_range_reducer;

  localparam int ANG_W = 32;
  localparam int K_W   = 6;
  localparam int K_MAX = 24;
  localparam longint LN2  = 45426;
  localparam longint HALF = 22713;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [ANG_W-1:0] x_in = '0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [ANG_W-1:0] r_out;
  logic signed [K_W-1:0]   k_out;
  logic                    ovf;
  logic                    unf;

  int n_checks = 0;
  int n_pass   = 0;

  exp_range_reducer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x_in      (x_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .k_out     (k_out),
    .ovf       (ovf),
    .unf       (unf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Reference model. k is the smallest shift count that brings the argument
  // into [-HALF, HALF], clamped to K_MAX with a flag if more shifts would be needed.
  typedef struct {
    longint r;
    longint k;
    bit     ovf;
    bit     unf;
    int     lat;
  } result_t;

  function automatic result_t model(input longint x);
    result_t res;
    longint  need;
    res.ovf = 0;
    res.unf = 0;
    if (x > HALF)       need = (x - HALF + LN2 - 1) / LN2;
    else if (x < -HALF) need = -((-x - HALF + LN2 - 1) / LN2);
    else                need = 0;
    if (need > K_MAX) begin
      res.k = K_MAX;  res.r = HALF;  res.ovf = 1;
    end else if (need < -K_MAX) begin
      res.k = -K_MAX; res.r = -HALF; res.unf = 1;
    end else begin
      res.k = need;   res.r = x - need * LN2;
    end
    res.lat = int'((res.k < 0) ? -res.k : res.k) + 1;
    return res;
  endfunction

  // One full transaction. Result fields and the number of edges from accept to
  // out_valid are returned. out_ready is held low until out_valid is observed.
  task automatic run_one(input longint x, output result_t got, output bit in_ready_low);
    int waited;
    got.lat = -1;
    in_ready_low = 1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    x_in     = ANG_W'(x);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      if (in_ready) in_ready_low = 0;
      @(posedge clk);
      #1;
      if (out_valid) begin
        got.lat = i;
        break;
      end
    end
    got.r   = longint'(r_out);
    got.k   = longint'(k_out);
    got.ovf = ovf;
    got.unf = unf;
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, " out_valid after release"}, longint'(out_valid), 0);
    check({tag, " in_ready after release"}, longint'(in_ready), 1);
  endtask

  task automatic run_and_check(input string tag, input longint x, input result_t exp);
    result_t got;
    bit      ir_low;
    run_one(x, got, ir_low);
    check({tag, " latency"}, got.lat, exp.lat);
    check({tag, " r_out"}, got.r, exp.r);
    check({tag, " k_out"}, got.k, exp.k);
    check({tag, " ovf"}, got.ovf, exp.ovf);
    check({tag, " unf"}, got.unf, exp.unf);
    check({tag, " in_ready low while busy"}, ir_low, 1);
    release_result(tag);
  endtask

  typedef struct {
    string   name;
    longint  x;
    result_t exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    result_t exp_res;
    result_t got;
    bit      ir_low;
    bit      stable;
    bit      seen_valid;
    logic signed [ANG_W-1:0] hold_r;
    logic signed [K_W-1:0]   hold_k;
    logic hold_ovf;
    logic hold_unf;

    vecs[0] = '{"one",       65536,    '{r:  20110, k:   1, ovf: 0, unf: 0, lat:  2}};
    vecs[1] = '{"minus_one", -65536,   '{r: -20110, k:  -1, ovf: 0, unf: 0, lat:  2}};
    vecs[2] = '{"five",      327680,   '{r:   9698, k:   7, ovf: 0, unf: 0, lat:  8}};
    vecs[3] = '{"half",      22713,    '{r:  22713, k:   0, ovf: 0, unf: 0, lat:  1}};
    vecs[4] = '{"half_p1",   22714,    '{r: -22712, k:   1, ovf: 0, unf: 0, lat:  2}};
    vecs[5] = '{"neg_half",  -22713,   '{r: -22713, k:   0, ovf: 0, unf: 0, lat:  1}};
    vecs[6] = '{"neg_half_m1", -22714, '{r:  22712, k:  -1, ovf: 0, unf: 0, lat:  2}};
    vecs[7] = '{"sat_pos",   1966080,  '{r:  22713, k:  24, ovf: 1, unf: 0, lat: 25}};
    vecs[8] = '{"sat_neg",   -1966080, '{r: -22713, k: -24, ovf: 0, unf: 1, lat: 25}};
    vecs[9] = '{"zero",      0,        '{r:      0, k:   0, ovf: 0, unf: 0, lat:  1}};

    // Reset: two cycles high, then check the idle outputs.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset in_ready", longint'(in_ready), 1);
    check("reset out_valid", longint'(out_valid), 0);
    check("reset r_out", longint'(r_out), 0);
    check("reset k_out", longint'(k_out), 0);
    check("reset ovf", longint'(ovf), 0);
    check("reset unf", longint'(unf), 0);

    // Directed table.
    for (int i = 0; i < 10; i++) run_and_check(vecs[i].name, vecs[i].x, vecs[i].exp);

    // Randomized arguments against the reference model, including saturating ones.
    for (int i = 0; i < 30; i++) begin
      longint x;
      x = longint'($urandom_range(0, 3_600_000)) - 1_800_000;
      if (i % 5 == 0) x = longint'($urandom_range(0, 90_000)) - 45_000;
      run_and_check($sformatf("rand%0d x=%0d", i, x), x, model(x));
    end

    // Backpressure: hold the result for 10 cycles while a stray in_valid is presented.
    run_one(327680, got, ir_low);
    check("bp latency", got.lat, 8);
    hold_r = r_out;
    hold_k = k_out;
    hold_ovf = ovf;
    hold_unf = unf;
    stable = 1;
    @(negedge clk);
    x_in = 32'sd65536;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (r_out !== hold_r || k_out !== hold_k || ovf !== hold_ovf || unf !== hold_unf ||
          out_valid !== 1'b1 || in_ready !== 1'b0) stable = 0;
    end
    check("bp outputs stable", stable, 1);
    check("bp r_out held", longint'(r_out), 9698);
    check("bp k_out held", longint'(k_out), 7);
    in_valid = 1'b0;
    release_result("bp");

    // Reset in the middle of REDUCE: argument is dropped, no result ever appears.
    @(negedge clk);
    x_in = 32'sd327680;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("midreset in_ready", longint'(in_ready), 1);
    check("midreset out_valid", longint'(out_valid), 0);
    check("midreset k_out", longint'(k_out), 0);
    check("midreset r_out", longint'(r_out), 0);
    seen_valid = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen_valid = 1;
    end
    check("midreset no out_valid", seen_valid, 0);

    // Normal operation resumes after the aborted argument.
    run_and_check("after_reset", 65536, model(65536));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
